irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_if.sv | 33 +++
 rtl/irq_ctrl.sv | 151 +++++++++++++++
 tb/tb_irq_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_ctrl_if -- register bus between the processor bridge and irq_ctrl.
//
// Signals:
//   Addr [1:0]  register select (bridge PrAddr[3:2])
//   WE          write strobe, one write per cycle it is high
//   DIN  [31:0] write data from the bridge
//   DOUT [31:0] read data back to the bridge, combinational on Addr
//
// Modports:
//   master -- the bridge side (drives Addr/WE/DIN, reads DOUT)
//   slave  -- the controller side (reads Addr/WE/DIN, drives DOUT)
// ---------------------------------------------------------------------------
interface irq_ctrl_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIN;
  logic [31:0] DOUT;

  modport master (
    output Addr,
    output WE,
    output DIN,
    input  DOUT
  );

  modport slave (
    input  Addr,
    input  WE,
    input  DIN,
    output DOUT
  );
endinterface

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl -- six-line interrupt controller with per-line mask and
// edge/level selection.
//
// Ports:
//   clk     single clock, all state changes on its rising edge
//   rst     synchronous active-low reset
//   bus     irq_ctrl_if.slave register bus (Addr, WE, DIN, DOUT)
//   irq_in  [5:0] interrupt request lines from the devices
//   HWInt   [5:0] pending & mask, to the CPU
//
// Register map (word address = Addr):
//   0  PEND   [5:0]  pending bits, write-1-to-clear
//   1  MASK   [5:0]  interrupt enable per line
//   2  EDGE   [5:0]  1 = rising-edge mode, 0 = level mode
//   3  STATUS [3:0] lowest pending+enabled index, [4] any pending+enabled,
//             [31:16] lost-edge counter (zero when the counter is not built)
//
// Build option:
//   IRQ_CTRL_LOSTCNT_EN  when defined, adds a 16-bit saturating counter of
//                        edges that arrive on an edge-mode line whose
//                        pending bit is already set. Any write to STATUS
//                        clears it.
// ---------------------------------------------------------------------------
module irq_ctrl #(
  parameter logic [5:0] RST_MASK = 6'h00,
  parameter logic [5:0] RST_EDGE = 6'h3F
) (
  input  logic            clk,
  input  logic            rst,
  irq_ctrl_if.slave       bus,
  input  logic [5:0]      irq_in,
  output logic [5:0]      HWInt
);

  logic [5:0] irq_q, irq_d;
  logic [5:0] pend_q, pend_d;
  logic [5:0] mask_q, mask_d;
  logic [5:0] edge_mode_q, edge_mode_d;

  logic [5:0] rise;
  logic [5:0] set_vec;
  logic [5:0] clr_vec;
  logic [5:0] active;
  logic [3:0] first_idx;
  logic       any_active;
  logic [15:0] lost_cnt;
  logic [31:0] status;

  logic wr_pend, wr_mask, wr_edge;

  assign wr_pend = bus.WE && (bus.Addr == 2'd0);
  assign wr_mask = bus.WE && (bus.Addr == 2'd1);
  assign wr_edge = bus.WE && (bus.Addr == 2'd2);

  assign rise = irq_in & ~irq_q;

  // Per-line set condition; the mode in effect is the one held before this
  // edge, so a write to EDGE only changes behaviour from the next edge on.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_set
      assign set_vec[gi] = edge_mode_q[gi] ? rise[gi] : irq_in[gi];
    end
  endgenerate

  assign clr_vec = wr_pend ? bus.DIN[5:0] : 6'h00;

  always_comb begin
    irq_d       = irq_in;
    // Set is ORed in after the clear so a simultaneous set wins.
    pend_d      = (pend_q & ~clr_vec) | set_vec;
    mask_d      = wr_mask ? bus.DIN[5:0] : mask_q;
    edge_mode_d = wr_edge ? bus.DIN[5:0] : edge_mode_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_q       <= 6'h00;
      pend_q      <= 6'h00;
      mask_q      <= RST_MASK;
      edge_mode_q <= RST_EDGE;
    end else begin
      irq_q       <= irq_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      edge_mode_q <= edge_mode_d;
    end
  end

  assign active = pend_q & mask_q;
  assign HWInt  = active;

  // Lowest set bit wins: scan from the top so lower indices overwrite.
  always_comb begin
    first_idx  = 4'd0;
    any_active = |active;
    for (int i = 5; i >= 0; i--) begin
      if (active[i]) begin
        first_idx = 4'(i);
      end
    end
  end

`ifdef IRQ_CTRL_LOSTCNT_EN
  logic [15:0] lost_q, lost_d;
  logic        lost_evt;
  logic        wr_status;

  assign wr_status = bus.WE && (bus.Addr == 2'd3);
  // At most one count per cycle no matter how many lines lose an edge.
  assign lost_evt  = |(edge_mode_q & rise & pend_q);

  always_comb begin
    lost_d = lost_q;
    if (wr_status) begin
      lost_d = 16'h0000;
    end else if (lost_evt && (lost_q != 16'hFFFF)) begin
      lost_d = lost_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lost_q <= 16'h0000;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign lost_cnt = lost_q;
`else
  assign lost_cnt = 16'h0000;
`endif

  assign status = {lost_cnt, 11'd0, any_active, first_idx};

  always_comb begin
    bus.DOUT = 32'h0;
    case (bus.Addr)
      2'd0:    bus.DOUT = {26'd0, pend_q};
      2'd1:    bus.DOUT = {26'd0, mask_q};
      2'd2:    bus.DOUT = {26'd0, edge_mode_q};
      default: bus.DOUT = status;
    endcase
  end

  // Upper write-data bits have no destination.
  logic unused_din;
  assign unused_din = ^bus.DIN[31:6];

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_irq_ctrl;
  localparam logic [5:0] P_RST_MASK = 6'h00;
  localparam logic [5:0] P_RST_EDGE = 6'h3F;

  logic       clk;
  logic       rst;
  logic [5:0] irq_in;
  logic [5:0] HWInt;

  irq_ctrl_if bus ();

  irq_ctrl #(.RST_MASK(P_RST_MASK), .RST_EDGE(P_RST_EDGE)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .irq_in (irq_in),
    .HWInt  (HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   m_pend [6];
  bit   m_mask [6];
  bit   m_edge [6];
  bit   m_prev [6];
  int   m_lost;
  bit   m_valid = 0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) begin
        m_pend[i] = 0;
        m_prev[i] = 0;
        m_mask[i] = P_RST_MASK[i];
        m_edge[i] = P_RST_EDGE[i];
      end
      m_lost  = 0;
      m_valid = 1;
    end else begin
      bit lost_now;
      bit new_pend [6];
      lost_now = 0;
      for (int i = 0; i < 6; i++) begin
        bit rising, fire, clear;
        rising = irq_in[i] && !m_prev[i];
        fire   = m_edge[i] ? rising : irq_in[i];
        clear  = bus.WE && bus.Addr == 2'd0 && bus.DIN[i];
        if (m_edge[i] && rising && m_pend[i]) lost_now = 1;
        if (fire) new_pend[i] = 1;
        else if (clear) new_pend[i] = 0;
        else new_pend[i] = m_pend[i];
      end
      if (bus.WE && bus.Addr == 2'd3) m_lost = 0;
      else if (lost_now && m_lost < 65535) m_lost = m_lost + 1;
      for (int i = 0; i < 6; i++) begin
        if (bus.WE && bus.Addr == 2'd1) m_mask[i] = bus.DIN[i];
        if (bus.WE && bus.Addr == 2'd2) m_edge[i] = bus.DIN[i];
        m_pend[i] = new_pend[i];
        m_prev[i] = irq_in[i];
      end
    end
  end

  function automatic logic [5:0] pack6(input bit v [6]);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    int first;
    first = -1;
    for (int i = 0; i < 6; i++)
      if (first < 0 && m_pend[i] && m_mask[i]) first = i;
    case (a)
      2'd0: r = {26'd0, pack6(m_pend)};
      2'd1: r = {26'd0, pack6(m_mask)};
      2'd2: r = {26'd0, pack6(m_edge)};
      default: begin
        r = 32'h0;
        if (first >= 0) r[4:0] = 5'h10 + 5'(first);
`ifdef IRQ_CTRL_LOSTCNT_EN
        r[31:16] = 16'(m_lost);
`endif
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_hwint", {26'd0, HWInt}, {26'd0, pack6(m_pend) & pack6(m_mask)});
      chk("model_dout", bus.DOUT, model_read(bus.Addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present inputs, let one rising edge consume them, return just after it.
  task automatic cyc(input logic [1:0] a, input logic we, input logic [31:0] d, input logic [5:0] irq);
    bus.Addr = a;
    bus.WE   = we;
    bus.DIN  = d;
    irq_in   = irq;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    bus.Addr = a;
    #1;
    v = bus.DOUT;
  endtask

  logic [31:0] rd;

  initial begin
    rst      = 1'b0;
    irq_in   = 6'h00;
    bus.Addr = 2'd0;
    bus.WE   = 1'b0;
    bus.DIN  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    chk("rst_hwint", {26'd0, HWInt}, 32'h0);
    peek(2'd0, rd); chk("rst_pend", rd, 32'h0);
    peek(2'd1, rd); chk("rst_mask", rd, 32'h0);
    peek(2'd2, rd); chk("rst_edge", rd, 32'h3F);
    peek(2'd3, rd); chk("rst_status", rd, 32'h0);

    // Pulse with mask bit 0 set, then W1C
    cyc(2'd1, 1'b1, 32'h1, 6'h00);
    cyc(2'd0, 1'b0, 32'h0, 6'h01);
    chk("pulse_hwint", {26'd0, HWInt}, 32'h01);
    peek(2'd3, rd); chk("pulse_status", rd, 32'h10);
    cyc(2'd0, 1'b1, 32'h1, 6'h00);
    chk("w1c_hwint", {26'd0, HWInt}, 32'h0);

    // Level mode held line survives W1C
    cyc(2'd2, 1'b1, 32'h0, 6'h00);
    cyc(2'd0, 1'b0, 32'h0, 6'h04);
    cyc(2'd0, 1'b1, 32'h4, 6'h04);
    peek(2'd0, rd); chk("level_hold", rd, 32'h04);
    cyc(2'd0, 1'b0, 32'h0, 6'h00);
    cyc(2'd0, 1'b1, 32'h4, 6'h00);
    peek(2'd0, rd); chk("level_clear", rd, 32'h00);

    // Masked line still latches, appears when unmasked
    cyc(2'd2, 1'b1, 32'h3F, 6'h00);
    cyc(2'd1, 1'b1, 32'h0, 6'h00);
    cyc(2'd0, 1'b0, 32'h0, 6'h20);
    cyc(2'd0, 1'b0, 32'h0, 6'h00);
    chk("masked_hwint", {26'd0, HWInt}, 32'h0);
    peek(2'd0, rd); chk("masked_pend", rd, 32'h20);
    cyc(2'd1, 1'b1, 32'h20, 6'h00);
    chk("unmask_hwint", {26'd0, HWInt}, 32'h20);

    // Priority encoding
    cyc(2'd0, 1'b1, 32'h3F, 6'h00);
    cyc(2'd1, 1'b1, 32'h3F, 6'h00);
    cyc(2'd0, 1'b0, 32'h0, 6'h0C);
    cyc(2'd0, 1'b0, 32'h0, 6'h00);
    peek(2'd3, rd); chk("status_12", {27'd0, rd[4:0]}, 32'h12);
    cyc(2'd0, 1'b1, 32'h4, 6'h00);
    peek(2'd3, rd); chk("status_13", {27'd0, rd[4:0]}, 32'h13);

    // Set beats simultaneous W1C
    cyc(2'd0, 1'b1, 32'h3F, 6'h00);
    cyc(2'd0, 1'b1, 32'h2, 6'h02);
    peek(2'd0, rd); chk("set_wins", rd, 32'h02);

    // STATUS write leaves low half alone
    cyc(2'd3, 1'b1, 32'hFFFF_FFFF, 6'h00);
    peek(2'd3, rd); chk("status_wr_low", {16'd0, rd[15:0]}, 32'h11);
`ifndef IRQ_CTRL_LOSTCNT_EN
    chk("status_hi_zero", {16'd0, rd[31:16]}, 32'h0);
`endif

    // Reset overrides write; line already high seen as edge after reset
    rst = 1'b0;
    cyc(2'd1, 1'b1, 32'h3F, 6'h01);
    rst = 1'b1;
    peek(2'd1, rd); chk("rst_over_wr", rd, {26'd0, P_RST_MASK});
    peek(2'd0, rd); chk("rst_over_irq", rd, 32'h0);
    cyc(2'd0, 1'b0, 32'h0, 6'h01);
    peek(2'd0, rd); chk("first_edge", rd, 32'h01);
    cyc(2'd0, 1'b1, 32'h1, 6'h00);

`ifdef IRQ_CTRL_LOSTCNT_EN
    cyc(2'd0, 1'b1, 32'h3F, 6'h00);
    cyc(2'd3, 1'b1, 32'h0, 6'h00);
    for (int k = 0; k < 3; k++) begin
      cyc(2'd0, 1'b0, 32'h0, 6'h01);
      cyc(2'd0, 1'b0, 32'h0, 6'h00);
    end
    peek(2'd3, rd); chk("lost_2", {16'd0, rd[31:16]}, 32'd2);
    cyc(2'd3, 1'b1, 32'h0, 6'h00);
    peek(2'd3, rd); chk("lost_clr", {16'd0, rd[31:16]}, 32'd0);
    // Alternate halves so every cycle carries an edge on a pending line.
    for (int k = 0; k < 65545; k++) begin
      irq_in = k[0] ? 6'h38 : 6'h07;
      @(posedge clk);
      #1;
    end
    peek(2'd3, rd); chk("lost_sat", {16'd0, rd[31:16]}, 32'h0000_FFFF);
    irq_in = 6'h00;
`endif

    // Randomized traffic, checked every cycle by the model compare
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3),
          $urandom, 6'($urandom));
    end
    rst = 1'b1;
    cyc(2'd0, 1'b0, 32'h0, 6'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
